// File: rtl/cast_router.sv
// cast_router: single-input FWFT flit buffer that multicasts each head flit to the
// masked outputs, retiring it only once every enabled output has taken it.
`ifndef DW
`define DW 32
`endif

module cast_router #(
    parameter logic [0:4] input_sel   = 5'b00000,
    parameter logic [0:4] output_mask = 5'b00000,
    parameter int         depth       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [`DW-1:0]   data_i  [5],
    input  logic [0:4]       valid_i,
    output logic [0:4]       ready_o,
    output logic [`DW-1:0]   data_o  [5],
    output logic [0:4]       valid_o,
    input  logic [0:4]       ready_i
);
    localparam int AW = $clog2(depth);

    logic [`DW-1:0] r_mem [depth];
    logic [AW-1:0]  r_wr, r_rd;
    logic [AW:0]    r_count;
    logic [0:4]     r_sent;
    logic           w_full, w_head, w_wr, w_pop;
    logic [0:4]     w_xfer, w_done;
    logic [`DW-1:0] w_din;

    always_comb begin
        w_din = '0;
        for (int j = 0; j < 5; j++)
            if (input_sel[j]) w_din = data_i[j];
    end

    assign w_full  = r_count == (AW+1)'(depth);
    assign w_head  = r_count != '0;
    // rst gating makes both handshakes drop the instant reset asserts
    assign ready_o = input_sel & {5{~w_full & ~rst}};
    assign valid_o = output_mask & ~r_sent & {5{w_head & ~rst}};
    assign w_wr    = |(valid_i & ready_o);
    assign w_xfer  = valid_o & ready_i;
    assign w_done  = ~output_mask | r_sent | w_xfer;
    assign w_pop   = w_head & (&w_done);

    for (genvar i = 0; i < 5; i++) begin : g_out
        assign data_o[i] = (output_mask[i] & w_head) ? r_mem[r_rd] : '0;
    end

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= w_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_sent  <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_sent  <= w_pop ? 5'b00000 : (r_sent | w_xfer);
        end
    end
endmodule

// File: tb/tb_cast_router.sv
// tb_cast_router: directed checks of a west->local unicast router (a_*) and a
// local->east|south multicast router (b_*) sharing clock and reset.
`ifndef DW
`define DW 32
`endif

module tb_cast_router;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [`DW-1:0] a_din [5], a_dout [5], b_din [5], b_dout [5];
    logic [0:4] a_vin, a_rdy_o, a_vout, a_rdy_i;
    logic [0:4] b_vin, b_rdy_o, b_vout, b_rdy_i;

    int n_chk = 0;
    int n_err = 0;

    cast_router #(.input_sel(5'b01000), .output_mask(5'b10000), .depth(8)) u_a (
        .clk(clk), .rst(rst), .data_i(a_din), .valid_i(a_vin), .ready_o(a_rdy_o),
        .data_o(a_dout), .valid_o(a_vout), .ready_i(a_rdy_i));

    cast_router #(.input_sel(5'b10000), .output_mask(5'b00101), .depth(8)) u_b (
        .clk(clk), .rst(rst), .data_i(b_din), .valid_i(b_vin), .ready_o(b_rdy_o),
        .data_o(b_dout), .valid_o(b_vout), .ready_i(b_rdy_i));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx [5];
        int nxt;
        for (int p = 0; p < 5; p++) begin
            a_din[p] = '0;
            b_din[p] = '0;
        end
        a_vin = '0; a_rdy_i = '0; b_vin = '0; b_rdy_i = '0;

        #3;
        chk("rst_a_vout", 32'(a_vout), 0);
        chk("rst_a_rdy", 32'(a_rdy_o), 0);
        chk("rst_b_rdy", 32'(b_rdy_o), 0);
        chk("rst_b_dout", b_dout[2], 0);
        step(); step();
        #2 rst = 0;
        step();
        chk("post_rst_a_rdy", 32'(a_rdy_o), 32'(5'b01000));
        chk("post_rst_b_rdy", 32'(b_rdy_o), 32'(5'b10000));

        // unicast west -> local
        a_rdy_i = '1;
        a_din[1] = 32'h3F800000; a_vin[1] = 1;
        chk("uni_empty", 32'(a_vout), 0);
        step();
        a_din[1] = 32'h40000000;
        chk("uni_v1", 32'(a_vout), 32'(5'b10000));
        chk("uni_d1", a_dout[0], 32'h3F800000);
        step();
        a_vin[1] = 0;
        chk("uni_v2", 32'(a_vout), 32'(5'b10000));
        chk("uni_d2", a_dout[0], 32'h40000000);
        step();
        chk("uni_drained", 32'(a_vout), 0);

        // non-selected north input is ignored
        a_vin[3] = 1; a_din[3] = 32'hDEAD0003;
        chk("nonsel_rdy", 32'(a_rdy_o), 32'(5'b01000));
        step(); step();
        a_vin[3] = 0;
        chk("nonsel_vout", 32'(a_vout), 0);
        chk("nonsel_dout", a_dout[0], 0);

        // fill to full with output stalled
        a_rdy_i = '0;
        for (int i = 0; i < 9; i++) begin
            a_din[1] = 32'h100 + 32'(i); a_vin[1] = 1;
            chk($sformatf("full_rdy%0d", i), 32'(a_rdy_o[1]), 32'(i < 8));
            step();
        end
        a_vin[1] = 0;
        chk("full_rdy_end", 32'(a_rdy_o), 0);
        a_rdy_i[0] = 1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_v%0d", k), 32'(a_vout[0]), 1);
            chk($sformatf("drain_d%0d", k), a_dout[0], 32'h100 + 32'(k));
            chk($sformatf("drain_rdy%0d", k), 32'(a_rdy_o[1]), 32'(k > 0));
            step();
        end
        chk("drain_empty", 32'(a_vout), 0);

        // multicast with south stalled
        b_rdy_i = 5'b00100;
        b_din[0] = 32'hA; b_vin[0] = 1;
        step();
        b_din[0] = 32'hB;
        chk("mc_v_a", 32'(b_vout), 32'(5'b00101));
        chk("mc_e_a", b_dout[2], 32'hA);
        chk("mc_s_a", b_dout[4], 32'hA);
        chk("mc_unmasked_d", b_dout[1], 0);
        step();
        b_din[0] = 32'hC;
        chk("mc_east_held", 32'(b_vout), 32'(5'b00001));
        chk("mc_s_hold", b_dout[4], 32'hA);
        step();
        b_vin[0] = 0;
        chk("mc_wait1", 32'(b_vout), 32'(5'b00001));
        step();
        b_rdy_i[4] = 1;
        chk("mc_wait2", 32'(b_vout), 32'(5'b00001));
        chk("mc_s_a2", b_dout[4], 32'hA);
        step();
        chk("mc_v_b", 32'(b_vout), 32'(5'b00101));
        chk("mc_e_b", b_dout[2], 32'hB);
        chk("mc_s_b", b_dout[4], 32'hB);
        step();
        chk("mc_e_c", b_dout[2], 32'hC);
        chk("mc_s_c", b_dout[4], 32'hC);
        step();
        chk("mc_empty", 32'(b_vout), 0);

        // asynchronous reset mid-stream
        b_rdy_i = 5'b00100;
        for (int i = 0; i < 5; i++) begin
            b_din[0] = 32'h200 + 32'(i); b_vin[0] = 1;
            step();
        end
        b_vin[0] = 0;
        chk("mr_pre_v", 32'(b_vout), 32'(5'b00001));
        #2 rst = 1;
        #1;
        chk("mr_vout", 32'(b_vout), 0);
        chk("mr_rdy", 32'(b_rdy_o), 0);
        chk("mr_dout", b_dout[4], 0);
        step();
        #2 rst = 0;
        step();
        chk("mr_post_rdy", 32'(b_rdy_o), 32'(5'b10000));
        chk("mr_post_v", 32'(b_vout), 0);
        b_rdy_i = '1;
        b_din[0] = 32'h55; b_vin[0] = 1;
        step();
        b_vin[0] = 0;
        chk("mr_new_v", 32'(b_vout), 32'(5'b00101));
        chk("mr_new_e", b_dout[2], 32'h55);
        step();
        chk("mr_new_empty", 32'(b_vout), 0);

        // wrap-around stream with random readiness
        idx = '{default: 0};
        nxt = 0;
        for (int c = 0; c < 600 && (idx[2] < 20 || idx[4] < 20); c++) begin
            b_vin[0] = (nxt < 20);
            b_din[0] = 32'(nxt);
            b_rdy_i[2] = 1'($urandom_range(0, 1));
            b_rdy_i[4] = 1'($urandom_range(0, 1));
            if (b_vin[0] && b_rdy_o[0]) nxt++;
            for (int p = 2; p <= 4; p += 2)
                if (b_vout[p] && b_rdy_i[p]) begin
                    chk($sformatf("wrap_p%0d", p), b_dout[p], 32'(idx[p]));
                    idx[p]++;
                end
            step();
        end
        b_vin[0] = 0;
        chk("wrap_east_cnt", 32'(idx[2]), 20);
        chk("wrap_south_cnt", 32'(idx[4]), 20);
        chk("wrap_empty", 32'(b_vout), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
